// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the receiver.
//   CYCLES_PER_SAMPLE_DEFAULT : clocks per bit period (both ends must agree)
//   DATA_BITS                 : payload bits per frame
//   RxState                   : receiver FSM states
//   START_BIT / STOP_BIT      : line levels of the framing bits
package uart_pkg;

    localparam int CYCLES_PER_SAMPLE_DEFAULT = 21812;
    localparam int DATA_BITS                 = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } RxState;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for a single asynchronous input. Both flops reset
// to 1 so that an idle-high line never shows a falling edge on reset release.
// Ports:
//   clk     : destination clock
//   reset_n : asynchronous active-low reset
//   din     : asynchronous input
//   dout    : input synchronized to clk
module uart_rx_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    logic meta_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_r <= 1'b1;
            dout   <= 1'b1;
        end else begin
            meta_r <= din;
            dout   <= meta_r;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver. Samples each bit at mid-period, checks the stop bit and
// holds the received byte in a one-entry register under valid/ready.
// Ports:
//   clk           : system clock
//   i_reset_n     : asynchronous active-low reset
//   i_rx          : serial line (asynchronous, idles high)
//   i_ready       : consumer takes o_data when o_valid && i_ready
//   o_data        : received byte, index 7 = LSB (first bit on the wire)
//   o_valid       : o_data holds an unconsumed byte
//   o_frame_error : one-cycle pulse, stop bit sampled low
//   o_overrun     : one-cycle pulse, good byte dropped (holding register full)
//   o_busy        : high whenever the FSM is not in IDLE
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CYCLES_PER_SAMPLE = CYCLES_PER_SAMPLE_DEFAULT
) (
    input  logic       clk,
    input  logic       i_reset_n,
    input  logic       i_rx,
    input  logic       i_ready,
    output logic [0:7] o_data,
    output logic       o_valid,
    output logic       o_frame_error,
    output logic       o_overrun,
    output logic       o_busy
);

    localparam int              IDX_W    = $clog2(DATA_BITS);
    localparam logic [23:0]     C_LAST   = 24'(CYCLES_PER_SAMPLE - 1);
    localparam logic [23:0]     H_LAST   = 24'((CYCLES_PER_SAMPLE / 2) - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    RxState                 state_r;
    RxState                 state_next_s;
    logic [23:0]            cnt_r;
    logic [23:0]            cnt_next_s;
    logic [IDX_W-1:0]       idx_r;
    logic [IDX_W-1:0]       idx_next_s;
    logic [DATA_BITS-1:0]   shift_r;
    logic                   rx_s;
    logic                   rx_prev_r;
    logic                   sample_data_s;
    logic                   deliver_s;
    logic                   frame_err_s;

    uart_rx_sync u_sync (
        .clk     (clk),
        .reset_n (i_reset_n),
        .din     (i_rx),
        .dout    (rx_s)
    );

    // FSM state, bit counter and bit index registers.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r <= IDLE;
            cnt_r   <= 24'd0;
            idx_r   <= '0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            idx_r   <= idx_next_s;
        end
    end

    // Next-state logic and per-cycle sample/deliver strobes.
    always_comb begin
        state_next_s  = state_r;
        cnt_next_s    = cnt_r;
        idx_next_s    = idx_r;
        sample_data_s = 1'b0;
        deliver_s     = 1'b0;
        frame_err_s   = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_next_s = 24'd0;
                if (rx_prev_r == STOP_BIT && rx_s == START_BIT) begin
                    state_next_s = START;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                if (cnt_r == H_LAST) begin
                    cnt_next_s = 24'd0;
                    idx_next_s = '0;
                    // A line back high at mid-start is a glitch, not a frame.
                    if (rx_s == START_BIT) begin
                        state_next_s = DATA;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    cnt_next_s = cnt_r + 24'd1;
                end
            end
            DATA: begin
                if (cnt_r == C_LAST) begin
                    cnt_next_s    = 24'd0;
                    sample_data_s = 1'b1;
                    if (idx_r == IDX_LAST) begin
                        idx_next_s   = '0;
                        state_next_s = STOP;
                    end else begin
                        idx_next_s = idx_r + 1'b1;
                    end
                end else begin
                    cnt_next_s = cnt_r + 24'd1;
                end
            end
            STOP: begin
                if (cnt_r == C_LAST) begin
                    cnt_next_s = 24'd0;
                    if (rx_s == STOP_BIT) begin
                        deliver_s    = 1'b1;
                        state_next_s = IDLE;
                    end else begin
                        frame_err_s  = 1'b1;
                        state_next_s = WAIT_IDLE;
                    end
                end else begin
                    cnt_next_s = cnt_r + 24'd1;
                end
            end
            WAIT_IDLE: begin
                // Hold off until the line recovers so a break is not a stream of starts.
                cnt_next_s = 24'd0;
                if (rx_s == STOP_BIT) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT_IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = 24'd0;
                idx_next_s   = '0;
            end
        endcase
    end

    // Shift register, edge-detect history, holding register and output flags.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            shift_r       <= '0;
            rx_prev_r     <= 1'b1;
            o_data        <= 8'h00;
            o_valid       <= 1'b0;
            o_frame_error <= 1'b0;
            o_overrun     <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            rx_prev_r     <= rx_s;
            o_busy        <= (state_next_s != IDLE);
            o_frame_error <= frame_err_s;
            o_overrun     <= deliver_s && o_valid && !i_ready;
            // LSB arrives first, so shift right and insert at the top.
            if (sample_data_s) begin
                shift_r <= {rx_s, shift_r[DATA_BITS-1:1]};
            end
            // A load in the same cycle as an accept keeps o_valid high with no bubble.
            if (deliver_s && (!o_valid || i_ready)) begin
                o_data  <= shift_r;
                o_valid <= 1'b1;
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
module tb_uart_receiver;

    localparam int C = 16;

    logic       clk = 1'b0;
    logic       i_reset_n;
    logic       i_rx;
    logic       i_ready;
    logic [0:7] o_data;
    logic       o_valid;
    logic       o_frame_error;
    logic       o_overrun;
    logic       o_busy;

    int checks   = 0;
    int failures = 0;
    int fe_cnt   = 0;
    int ov_cnt   = 0;
    logic [7:0] exp_q[$];

    uart_receiver #(.CYCLES_PER_SAMPLE(C)) dut (
        .clk           (clk),
        .i_reset_n     (i_reset_n),
        .i_rx          (i_rx),
        .i_ready       (i_ready),
        .o_data        (o_data),
        .o_valid       (o_valid),
        .o_frame_error (o_frame_error),
        .o_overrun     (o_overrun),
        .o_busy        (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: values read here are the pre-edge values.
    always @(posedge clk) begin
        if (i_reset_n) begin
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte: got %0h expected none", o_data);
                end else begin
                    check("byte", {24'h0, o_data}, {24'h0, exp_q.pop_front()});
                end
            end
            if (o_frame_error && o_overrun) begin
                checks++;
                failures++;
                $display("FAIL flags_together: got fe=1 ov=1 expected not both");
            end
            if (o_frame_error) fe_cnt++;
            if (o_overrun) ov_cnt++;
        end
    end

    // Drives one 8N1 frame; caller must be at a negedge.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        i_rx = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            i_rx = b[i];
            repeat (C) @(negedge clk);
        end
        i_rx = stop;
        repeat (C) @(negedge clk);
        i_rx = 1'b1;
    endtask

    int fe0;
    int ov0;

    initial begin
        i_reset_n = 1'b0;
        i_rx      = 1'b1;
        i_ready   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data", {24'h0, o_data}, 32'h0);
        check("rst_valid", {31'h0, o_valid}, 32'h0);
        check("rst_fe", {31'h0, o_frame_error}, 32'h0);
        check("rst_ov", {31'h0, o_overrun}, 32'h0);
        check("rst_busy", {31'h0, o_busy}, 32'h0);
        i_reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Basic frame with latency check: valid first seen at D+H+9C+1 = 155.
        i_ready = 1'b1;
        fe0 = fe_cnt; ov0 = ov_cnt;
        exp_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (4) @(negedge clk);
                check("a5_busy_early", {31'h0, o_busy}, 32'h1);
                repeat (150) @(negedge clk);
                check("a5_valid_154", {31'h0, o_valid}, 32'h0);
                @(negedge clk);
                check("a5_valid_155", {31'h0, o_valid}, 32'h1);
                check("a5_data_155", {24'h0, o_data}, 32'hA5);
            end
        join
        repeat (5) @(negedge clk);
        check("a5_flags", fe_cnt - fe0 + ov_cnt - ov0, 32'h0);
        check("a5_busy_after", {31'h0, o_busy}, 32'h0);

        // Framing error followed by a break, then a good frame.
        fe0 = fe_cnt;
        send_frame(8'h55, 1'b0);
        i_rx = 1'b0;
        repeat (40) @(negedge clk);
        check("fe_count", fe_cnt - fe0, 32'h1);
        check("fe_valid", {31'h0, o_valid}, 32'h0);
        check("fe_wait_busy", {31'h0, o_busy}, 32'h1);
        i_rx = 1'b1;
        repeat (10) @(negedge clk);
        check("fe_recover_busy", {31'h0, o_busy}, 32'h0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        repeat (5) @(negedge clk);
        check("3c_drained", exp_q.size(), 32'h0);

        // Short glitch on the idle line.
        fe0 = fe_cnt; ov0 = ov_cnt;
        i_rx = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_busy", {31'h0, o_busy}, 32'h1);
        i_rx = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_busy_after", {31'h0, o_busy}, 32'h0);
        check("glitch_valid", {31'h0, o_valid}, 32'h0);
        check("glitch_flags", fe_cnt - fe0 + ov_cnt - ov0, 32'h0);

        // Overrun: three frames back-to-back while the consumer stalls.
        i_ready = 1'b0;
        ov0 = ov_cnt;
        exp_q.push_back(8'h01);
        send_frame(8'h01, 1'b1);
        send_frame(8'h02, 1'b1);
        send_frame(8'h03, 1'b1);
        repeat (5) @(negedge clk);
        check("ovr_count", ov_cnt - ov0, 32'h2);
        check("ovr_data", {24'h0, o_data}, 32'h01);
        check("ovr_valid", {31'h0, o_valid}, 32'h1);
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        check("ovr_valid_drop", {31'h0, o_valid}, 32'h0);

        // Asynchronous reset during data bit 4.
        i_rx = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            i_rx = i[0];
            repeat (C) @(negedge clk);
        end
        i_rx = 1'b1;
        repeat (8) @(negedge clk);
        check("mid_busy", {31'h0, o_busy}, 32'h1);
        i_reset_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'h0, o_busy}, 32'h0);
        check("mid_rst_data", {24'h0, o_data}, 32'h0);
        check("mid_rst_valid", {31'h0, o_valid}, 32'h0);
        @(negedge clk);
        i_reset_n = 1'b1;
        repeat (20) @(negedge clk);
        i_ready = 1'b1;
        exp_q.push_back(8'hFF);
        send_frame(8'hFF, 1'b1);
        repeat (5) @(negedge clk);
        check("ff_drained", exp_q.size(), 32'h0);

        // New byte loads in the same cycle the previous one is accepted.
        i_ready = 1'b0;
        ov0 = ov_cnt;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        exp_q.push_back(8'h22);
        fork
            send_frame(8'h22, 1'b1);
            begin
                repeat (154) @(negedge clk);
                i_ready = 1'b1;
                @(negedge clk);
                i_ready = 1'b0;
                check("swap_valid", {31'h0, o_valid}, 32'h1);
                check("swap_data", {24'h0, o_data}, 32'h22);
            end
        join
        repeat (3) @(negedge clk);
        check("swap_no_ovr", ov_cnt - ov0, 32'h0);
        i_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("final_drained", exp_q.size(), 32'h0);
        check("final_valid", {31'h0, o_valid}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receiver: the downstream counterpart of `uart_transmitter`, consuming its `o_tx` line (8N1: start 0, eight data bits LSB-first, stop 1). The block samples each bit at mid-period, checks the frame, and holds the received byte in a one-entry output register under a valid/ready handshake. Overrun and framing errors are flagged.

## Interface
- `CYCLES_PER_SAMPLE`, default 21812: clocks per bit period; must equal the transmitter's value; legal range 4..2^24-1.
- `clk`  input  1  system clock.
- `i_reset_n`  input  1  asynchronous, active-low reset.
- `i_rx`  input  1  serial line, asynchronous to `clk`, idles high.
- `i_ready`  input  1  consumer accepts `o_data` in any cycle where `o_valid && i_ready`.
- `o_data`  output  [0:7]  received byte; index 7 is the LSB (first data bit on the wire), index 0 the MSB.
- `o_valid`  output  1  `o_data` holds an unconsumed byte.
- `o_frame_error`  output  1  one-cycle pulse: stop bit sampled low.
- `o_overrun`  output  1  one-cycle pulse: a good frame was dropped because the holding register was full.
- `o_busy`  output  1  high in every state except IDLE.

## Operation
- Reset: one clock and one reset only. Reset is asynchronous and active-low (`i_reset_n`).
- `i_rx` passes through a 2-flop synchronizer. Both flops reset to 1, so reset release never produces a false start.
- `o_data`=0, `o_valid`=0, `o_frame_error`=0, `o_overrun`=0, `o_busy`=0 on reset. State resets to IDLE; counters reset to 0.
- H = CYCLES_PER_SAMPLE/2 (integer division). C = CYCLES_PER_SAMPLE.
- States:
  - IDLE: on a falling edge of the synchronized line (previous 1, current 0), go to START and clear the cycle counter.
  - START: when the counter reaches H-1, resample the line. If low, go to DATA with bit index 0 and counter 0. If high, treat it as a glitch and return to IDLE with no flag.
  - DATA: when the counter reaches C-1, sample the line into the shift register and clear the counter. After the 8th sample, go to STOP.
  - STOP: when the counter reaches C-1, sample the line.
    - If the sample is 1, deliver the byte and go to IDLE.
    - If the sample is 0, pulse `o_frame_error`, discard the byte, and go to WAIT_IDLE.
  - WAIT_IDLE: stay until the synchronized line is 1, then go to IDLE. This prevents a break condition from being read as back-to-back start bits.
- Delivery of a good byte:
  - If `o_valid`=0, or `i_ready`=1 in the same cycle, load `o_data` and set `o_valid`=1. The simultaneous accept of the old byte and load of the new one keeps `o_valid` high with no bubble.
  - Otherwise keep the old byte, drop the new one, and pulse `o_overrun`.
- `o_valid` clears on the cycle after `o_valid && i_ready` unless a new byte loads in that same cycle.
- Counter is 24 bits wide and wraps only by explicit clear; it never free-runs past C-1.
- An asynchronous reset asserted mid-frame returns the block immediately to IDLE with all outputs at reset values. A partial byte is never delivered.

## Timing
- D = the first cycle the synchronized line is seen low, which is 2 clocks after `i_rx` falls at a clock edge.
- Sample points fall at cycles D+H (start), D+H+kC for k=1..8 (data), and D+H+9C (stop).
- `o_valid` rises, or `o_frame_error`/`o_overrun` pulses, in cycle D+H+9C+1.
- `o_busy` is high from D+1 until the return to IDLE.
- A new start edge is accepted in the first IDLE cycle after the stop sample. Back-to-back transmitter frames are therefore received with no loss.
- `o_frame_error` and `o_overrun` are never high in the same cycle.

## Structure
- Shared package `uart_pkg` holds:
  - the default `CYCLES_PER_SAMPLE`, which the transmitter also moves to;
  - `DATA_BITS` = 8;
  - the `RxState` enum {IDLE, START, DATA, STOP, WAIT_IDLE};
  - the frame constants START_BIT=0 and STOP_BIT=1.
- One sub-module, `uart_rx_sync`: a 2-flop synchronizer with reset value 1, reusable for any asynchronous input.
- Everything else (FSM, counter, shift register, holding register) is flat in `uart_receiver`.

## Test plan
All scenarios use CYCLES_PER_SAMPLE=16.
- Loopback from `uart_transmitter` sending 8'hA5, `i_ready`=1 → one `o_valid` cycle with `o_data`=8'hA5 at D+8+144+1, and no error flags.
- Serial frame with the stop bit driven 0 and the line held low for 40 cycles → `o_frame_error` pulses once, `o_valid` stays 0, and the block stays in WAIT_IDLE until the line rises. The next frame 8'h3C is received correctly.
- 4-cycle low glitch on an idle line → returns to IDLE after the start check, with no `o_valid` and no flags.
- Three back-to-back frames 8'h01, 8'h02, 8'h03 with `i_ready`=0 → `o_data` stays 8'h01 and `o_overrun` pulses twice. After `i_ready`=1 for one cycle, `o_valid` drops.
- `i_reset_n` pulsed low during data bit 4 → all outputs are 0 immediately. A full frame 8'hFF sent after release is received exactly once.
- Frame completes in the same cycle as `o_valid && i_ready` on the prior byte 8'h11 (new byte 8'h22) → `o_valid` stays 1, `o_data` becomes 8'h22, no overrun.
